// File: rtl/lzw_encoder_pkg.sv
// rtl/lzw_encoder_pkg.sv - shared state encodings and helpers for the LZ78 encoder
package lzw_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEARCH,
    ST_EMIT,
    ST_FLUSH,
    ST_DONE
  } enc_state_e;

  typedef enum logic {
    GRP_IDLE,
    GRP_SCAN
  } grp_state_e;

  // Requested lengths beyond the RAM depth are limited to the whole RAM.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/lzw_encoder_grouper.sv
// rtl/lzw_encoder_grouper.sv - sequential vocab scanner, one entry per cycle, ascending from 1
module lzw_encoder_grouper
  import lzw_encoder_pkg::*;
#(
  parameter int VAW = 5,
  parameter int DW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [VAW-1:0] w,
  input  logic [DW-1:0]  c,
  input  logic [VAW:0]   npv,
  input  logic [VAW-1:0] rd_prefix,
  input  logic [DW-1:0]  rd_ch,
  output logic [VAW-1:0] scan_addr,
  output logic           hit,
  output logic [VAW-1:0] hit_code,
  output logic           done
);

  localparam logic [VAW:0] IDX_ONE = (VAW+1)'(1);

  grp_state_e   state_q, state_d;
  logic [VAW:0] idx_q, idx_d;
  logic         active;
  logic         match;
  logic         last;

  // Compare the entry under the cursor and advance until a hit or the last live entry.
  always_comb begin
    active    = (state_q == GRP_SCAN);
    match     = active && (rd_prefix == w) && (rd_ch == c);
    last      = ((idx_q + IDX_ONE) == npv);
    scan_addr = idx_q[VAW-1:0];
    hit       = match;
    hit_code  = idx_q[VAW-1:0];
    done      = active && (match || last);
    state_d   = state_q;
    idx_d     = idx_q;
    if (start) begin
      idx_d   = IDX_ONE;
      state_d = (npv > IDX_ONE) ? GRP_SCAN : GRP_IDLE;
    end else if (active) begin
      if (match || last) begin
        state_d = GRP_IDLE;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  // Scanner state and cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GRP_IDLE;
      idx_q   <= IDX_ONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/lzw_encoder.sv
// rtl/lzw_encoder.sv - LZ78 encoder top; optional busy-cycle counter under LZW_ENCODER_CYCLE_CNT_EN
module lzw_encoder
  import lzw_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH       = 4,
  parameter int VOCAB_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        in_we,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [ADDR_WIDTH:0]         in_len,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [VOCAB_ADDR_WIDTH-1:0] rd_code,
  output logic [DATA_WIDTH-1:0]       rd_char,
  output logic                        busy,
  output logic                        done,
`ifdef LZW_ENCODER_CYCLE_CNT_EN
  output logic [15:0]                 cycle_count,
`endif
  output logic [ADDR_WIDTH:0]         out_count
);

  localparam int AW     = ADDR_WIDTH;
  localparam int VAW    = VOCAB_ADDR_WIDTH;
  localparam int DW     = DATA_WIDTH;
  localparam int DEPTH  = 2 ** AW;
  localparam int VDEPTH = 2 ** VAW;

  localparam logic [AW:0]  LEN_ONE  = (AW+1)'(1);
  localparam logic [VAW:0] NPV_ONE  = (VAW+1)'(1);
  localparam logic [VAW:0] NPV_FULL = (VAW+1)'(VDEPTH);

  typedef struct packed {
    logic [VAW-1:0] prefix;
    logic [DW-1:0]  ch;
  } vocab_entry_t;

  logic [DW-1:0]  in_mem       [DEPTH];
  logic [VAW-1:0] out_code_mem [DEPTH];
  logic [DW-1:0]  out_char_mem [DEPTH];
  vocab_entry_t   vocab_mem    [VDEPTH];

  enc_state_e     state_q, state_d;
  logic [AW:0]    len_q, len_d;
  logic [VAW:0]   npv_q, npv_d;
  logic [AW:0]    npo_q, npo_d;
  logic [VAW-1:0] w_q, w_d;
  logic [AW:0]    i_q, i_d;
  logic [DW-1:0]  c_q, c_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [AW:0]    count_q, count_d;

  logic           in_wr;
  logic           out_wr;
  logic [VAW-1:0] out_wr_code;
  logic [DW-1:0]  out_wr_char;
  logic           vocab_wr;
  vocab_entry_t   vocab_wr_entry;
  vocab_entry_t   flush_entry;
  logic [AW:0]    next_i;
  logic [AW:0]    start_len;

  logic           grp_start;
  logic [VAW-1:0] grp_addr;
  logic           grp_hit;
  logic [VAW-1:0] grp_code;
  logic           grp_done;

  assign grp_start = (state_q == ST_FETCH);

  lzw_encoder_grouper #(
    .VAW(VAW),
    .DW (DW)
  ) u_grouper (
    .clk      (clk),
    .rst      (rst),
    .start    (grp_start),
    .w        (w_q),
    .c        (c_q),
    .npv      (npv_q),
    .rd_prefix(vocab_mem[grp_addr].prefix),
    .rd_ch    (vocab_mem[grp_addr].ch),
    .scan_addr(grp_addr),
    .hit      (grp_hit),
    .hit_code (grp_code),
    .done     (grp_done)
  );

  // Next-state logic for the encoder FSM and RAM write strobes.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    npv_d          = npv_q;
    npo_d          = npo_q;
    w_d            = w_q;
    i_d            = i_q;
    c_d            = c_q;
    count_d        = count_q;
    in_wr          = in_we && (state_q == ST_IDLE) && !rst;
    out_wr         = 1'b0;
    out_wr_code    = '0;
    out_wr_char    = '0;
    vocab_wr       = 1'b0;
    vocab_wr_entry = '0;
    next_i         = i_q + LEN_ONE;
    flush_entry    = vocab_mem[w_q];
    start_len      = (AW+1)'(clamp_len(32'(in_len), DEPTH));
    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          len_d = start_len;
          npv_d = NPV_ONE;
          npo_d = '0;
          w_d   = '0;
          i_d   = '0;
          if (start_len == '0) begin
            state_d = ST_DONE;
            count_d = '0;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        c_d     = in_mem[i_q[AW-1:0]];
        state_d = (npv_q == NPV_ONE) ? ST_EMIT : ST_SEARCH;
      end
      ST_SEARCH: begin
        if (grp_done) begin
          if (grp_hit) begin
            w_d     = grp_code;
            i_d     = next_i;
            state_d = (next_i == len_q) ? ST_FLUSH : ST_FETCH;
          end else begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        out_wr      = 1'b1;
        out_wr_code = w_q;
        out_wr_char = c_q;
        npo_d       = npo_q + LEN_ONE;
        if (npv_q < NPV_FULL) begin
          vocab_wr              = 1'b1;
          vocab_wr_entry.prefix = w_q;
          vocab_wr_entry.ch     = c_q;
          npv_d                 = npv_q + NPV_ONE;
        end
        w_d = '0;
        i_d = next_i;
        if (next_i == len_q) begin
          state_d = ST_DONE;
          count_d = npo_d;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        // A pending match re-emits the pair that created its vocab entry.
        if (w_q != '0) begin
          out_wr      = 1'b1;
          out_wr_code = flush_entry.prefix;
          out_wr_char = flush_entry.ch;
          npo_d       = npo_q + LEN_ONE;
        end
        state_d = ST_DONE;
        count_d = npo_d;
      end
      ST_DONE: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_SEARCH) ||
             (state_d == ST_EMIT)  || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
    if (rst) begin
      out_wr   = 1'b0;
      vocab_wr = 1'b0;
    end
  end

  // Encoder FSM registers with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      npv_q   <= NPV_ONE;
      npo_q   <= '0;
      w_q     <= '0;
      i_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      npv_q   <= npv_d;
      npo_q   <= npo_d;
      w_q     <= w_d;
      i_q     <= i_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // RAM writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (in_wr) begin
      in_mem[in_addr] <= in_data;
    end
    if (out_wr) begin
      out_code_mem[npo_q[AW-1:0]] <= out_wr_code;
      out_char_mem[npo_q[AW-1:0]] <= out_wr_char;
    end
    if (vocab_wr) begin
      vocab_mem[npv_q[VAW-1:0]] <= vocab_wr_entry;
    end
  end

  assign rd_code   = out_code_mem[rd_addr];
  assign rd_char   = out_char_mem[rd_addr];
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_count = count_q;

`ifdef LZW_ENCODER_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Busy-cycle counter: cleared on start, saturating, frozen outside a run.
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == ST_IDLE) && cs) begin
      cyc_d = '0;
    end else if (busy_q && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_lzw_encoder.sv
// tb/tb_lzw_encoder.sv - scoreboard bench for lzw_encoder (default VAW=5 and a VAW=2 instance)
`timescale 1ns/1ps
module tb_lzw_encoder;
  import lzw_encoder_pkg::*;

  typedef struct {
    int                 dut;
    int                 n;
    string              name;
    logic [15:0][12:0]  pairs;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       cs = '0;
  logic [1:0]       in_we = '0;
  logic [1:0][3:0]  in_addr = '0;
  logic [1:0][7:0]  in_data = '0;
  logic [1:0][4:0]  in_len = '0;
  logic [1:0][3:0]  rd_addr = '0;
  logic [4:0]       rd_code0;
  logic [1:0]       rd_code1;
  logic [1:0][7:0]  rd_char;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0][4:0]  out_count;

  int checks = 0;
  int errors = 0;
  int exp_runs = 0;
  int mon_runs = 0;
  exp_t sbq[$];

  always #10 clk = ~clk;

  lzw_encoder #(.ADDR_WIDTH(4), .VOCAB_ADDR_WIDTH(5), .DATA_WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .cs(cs[0]), .in_we(in_we[0]), .in_addr(in_addr[0]),
    .in_data(in_data[0]), .in_len(in_len[0]), .rd_addr(rd_addr[0]), .rd_code(rd_code0),
    .rd_char(rd_char[0]), .busy(busy[0]), .done(done[0]), .out_count(out_count[0])
  );

  lzw_encoder #(.ADDR_WIDTH(4), .VOCAB_ADDR_WIDTH(2), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .cs(cs[1]), .in_we(in_we[1]), .in_addr(in_addr[1]),
    .in_data(in_data[1]), .in_len(in_len[1]), .rd_addr(rd_addr[1]), .rd_code(rd_code1),
    .rd_char(rd_char[1]), .busy(busy[1]), .done(done[1]), .out_count(out_count[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] pr(input int code, input int ch);
    logic [4:0] c5;
    logic [7:0] c8;
    c5 = code[4:0];
    c8 = ch[7:0];
    return {c5, c8};
  endfunction

  task automatic push_exp(input int d, input string name, input int n, input logic [15:0][12:0] p);
    exp_t e;
    e.dut = d;
    e.n = n;
    e.name = name;
    e.pairs = p;
    sbq.push_back(e);
    exp_runs++;
  endtask

  task automatic load(input int d, input int n, input logic [15:0][7:0] data);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_we[d] = 1'b1;
      in_addr[d] = k[3:0];
      in_data[d] = data[k];
    end
    @(negedge clk);
    in_we[d] = 1'b0;
  endtask

  // Start a run, optionally poke the input RAM while busy, wait for done and the monitor, hold, release.
  task automatic run(input int d, input int len, input int hold, input bit poke,
                     output int cyc, output int bcnt);
    int t;
    @(negedge clk);
    cs[d] = 1'b1;
    in_len[d] = len[4:0];
    cyc = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy[d]) bcnt++;
      if (poke && busy[d]) begin
        in_we[d] = 1'b1;
        in_addr[d] = 4'(cyc % 5);
        in_data[d] = 8'h5A;
      end
    end while (!done[d] && cyc < 400);
    in_we[d] = 1'b0;
    chk("run_done_seen", done[d], 1);
    t = 0;
    while (mon_runs < exp_runs && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("monitor_caught_up", mon_runs, exp_runs);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("done_holds_with_cs", done[d], 1);
    end
    cs[d] = 1'b0;
    @(negedge clk);
    chk("done_drops_without_cs", done[d], 0);
    chk("busy_low_after_run", busy[d], 0);
  endtask

  task automatic check_run(input int d);
    exp_t e;
    logic [4:0] code;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_done", sbq.size(), 1);
      return;
    end
    e = sbq.pop_front();
    chk({e.name, "_dut"}, d, e.dut);
    chk({e.name, "_out_count"}, out_count[d], e.n);
    for (int k = 0; k < e.n; k++) begin
      rd_addr[d] = k[3:0];
      #1;
      code = (d == 0) ? rd_code0 : {3'b000, rd_code1};
      chk($sformatf("%s_code%0d", e.name, k), code, e.pairs[k][12:8]);
      chk($sformatf("%s_char%0d", e.name, k), rd_char[d], e.pairs[k][7:0]);
    end
    mon_runs++;
  endtask

  // Monitor: every rising done is matched against the oldest expected run.
  initial begin
    logic [1:0] prev;
    logic [1:0] now;
    prev = '0;
    forever begin
      @(negedge clk);
      now = done;
      for (int d = 0; d < 2; d++) begin
        if (now[d] && !prev[d]) check_run(d);
      end
      prev = now;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][7:0]  txt;
    logic [15:0][12:0] p;
    int cyc, bcnt, t;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_busy%0d", d), busy[d], 0);
      chk($sformatf("reset_done%0d", d), done[d], 0);
      chk($sformatf("reset_out_count%0d", d), out_count[d], 0);
    end

    // "ABABA" -> (0,41)(0,42)(1,42)(0,41)
    txt = '0;
    txt[0] = 8'h41; txt[1] = 8'h42; txt[2] = 8'h41; txt[3] = 8'h42; txt[4] = 8'h41;
    load(0, 5, txt);
    p = '0;
    p[0] = pr(0, 'h41); p[1] = pr(0, 'h42); p[2] = pr(1, 'h42); p[3] = pr(0, 'h41);
    push_exp(0, "ababa", 4, p);
    run(0, 5, 0, 1'b0, cyc, bcnt);

    // "AAAA" -> (0,41)(1,41)(0,41)
    txt = '0;
    txt[0] = 8'h41; txt[1] = 8'h41; txt[2] = 8'h41; txt[3] = 8'h41;
    load(0, 4, txt);
    p = '0;
    p[0] = pr(0, 'h41); p[1] = pr(1, 'h41); p[2] = pr(0, 'h41);
    push_exp(0, "aaaa", 3, p);
    run(0, 4, 0, 1'b0, cyc, bcnt);
    chk("aaaa_vocab1", u_dut0.vocab_mem[1], {5'd0, 8'h41});
    chk("aaaa_vocab2", u_dut0.vocab_mem[2], {5'd1, 8'h41});
    chk("aaaa_npv", u_dut0.npv_q, 3);

    // VAW=2: dictionary fills at 4 and stops adding
    txt = '0;
    txt[0] = 8'h41; txt[1] = 8'h42; txt[2] = 8'h43; txt[3] = 8'h44; txt[4] = 8'h41;
    load(1, 5, txt);
    p = '0;
    p[0] = pr(0, 'h41); p[1] = pr(0, 'h42); p[2] = pr(0, 'h43); p[3] = pr(0, 'h44); p[4] = pr(0, 'h41);
    push_exp(1, "abcda_vaw2", 5, p);
    run(1, 5, 0, 1'b0, cyc, bcnt);
    chk("abcda_npv_full", u_dut1.npv_q, 4);

    // Reset while in SEARCH aborts to IDLE
    txt = '0;
    txt[0] = 8'h41; txt[1] = 8'h42; txt[2] = 8'h41; txt[3] = 8'h42; txt[4] = 8'h41;
    load(0, 5, txt);
    @(negedge clk);
    cs[0] = 1'b1;
    in_len[0] = 5'd5;
    t = 0;
    while (u_dut0.state_q != ST_SEARCH && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reached_search", u_dut0.state_q, ST_SEARCH);
    rst = 1'b1;
    cs[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", u_dut0.state_q, ST_IDLE);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_done", done[0], 0);
    chk("rst_mid_out_count", out_count[0], 0);
    rst = 1'b0;

    // Rerun from preserved RAM, poking in_we while busy and holding cs in DONE
    p = '0;
    p[0] = pr(0, 'h41); p[1] = pr(0, 'h42); p[2] = pr(1, 'h42); p[3] = pr(0, 'h41);
    push_exp(0, "ababa_rerun", 4, p);
    run(0, 5, 4, 1'b1, cyc, bcnt);
    chk("poke_in_mem0", u_dut0.in_mem[0], 8'h41);
    chk("poke_in_mem1", u_dut0.in_mem[1], 8'h42);
    chk("poke_in_mem4", u_dut0.in_mem[4], 8'h41);

    // len=0 goes straight to DONE with no pairs
    p = '0;
    push_exp(0, "len0", 0, p);
    run(0, 0, 0, 1'b0, cyc, bcnt);
    chk("len0_done_within_2", (cyc <= 2), 1);
    chk("len0_busy_at_most_1", (bcnt <= 1), 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
